oram_path_ctrl: RTL and testbench

ORAM_PATH_CTRL -- requirements
Module: oram_path_ctrl

---
 rtl/oram_path_ctrl.sv | 255 +++++++++++++++++++++++++
 tb/tb_oram_path_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oram_path_ctrl.sv
// Path-ORAM controller: remap block to a fresh random leaf, pull its path into the stash,
// answer the request, then greedily write the same path back. Macro ORAM_STASH_MON_EN adds stash monitors.
module oram_path_ctrl #(
    parameter int          BLK_W = 64,
    parameter int          L     = 6,
    parameter int          Z     = 3,
    parameter int          STASH = 8,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [L-1:0]     req_addr,
    input  logic [BLK_W-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [BLK_W-1:0] rsp_rdata,
    output logic             rsp_hit,
`ifdef ORAM_STASH_MON_EN
    output logic             overflow,
    output logic [$clog2(STASH+1)-1:0] stash_occ,
    output logic [$clog2(STASH+1)-1:0] stash_peak
`else
    output logic             overflow
`endif
);
    localparam int LW     = L - 1;
    localparam int NODES  = 1 << L;
    localparam int SLOTS  = NODES * Z;
    localparam int SI_W   = $clog2(SLOTS);
    localparam int ST_W   = (STASH > 1) ? $clog2(STASH) : 1;
    localparam int LVL_W  = (L > 1) ? $clog2(L) : 1;
    localparam int SLOT_W = (Z > 1) ? $clog2(Z) : 1;

    typedef enum logic [2:0] {IDLE, REMAP, READ, RESPOND, EVICT} state_t;
    state_t state_reg, state_next;

    // Tree buckets, flattened as node*Z + slot; node 0 is unused
    logic [SLOTS-1:0] bkt_valid_reg;
    logic [L-1:0]     bkt_addr [SLOTS];
    logic [LW-1:0]    bkt_leaf [SLOTS];
    logic [BLK_W-1:0] bkt_data [SLOTS];

    logic [NODES-1:0] pm_valid_reg;
    logic [LW-1:0]    pm_leaf [NODES];

    logic [STASH-1:0] st_valid_reg;
    logic [L-1:0]     st_addr [STASH];
    logic [LW-1:0]    st_leaf [STASH];
    logic [BLK_W-1:0] st_data [STASH];

    logic [15:0]       lfsr_reg;
    logic              rq_write_reg;
    logic [L-1:0]      rq_addr_reg;
    logic [BLK_W-1:0]  rq_wdata_reg;
    logic [LW-1:0]     old_leaf_reg;
    logic [LW-1:0]     new_leaf_reg;
    logic [LVL_W-1:0]  lvl_reg;
    logic [SLOT_W-1:0] slot_reg;
    logic              overflow_reg;

    logic [LW-1:0]   lfsr_leaf;
    logic [L-1:0]    cur_node;
    logic [SI_W-1:0] cur_idx;
    logic [LW-1:0]   lvl_mask;
    logic            free_found, hit_found, ev_found;
    logic [ST_W-1:0] free_idx, hit_idx, ev_idx;
    logic            last_read, last_evict;

    function automatic logic [L-1:0] path_node(input logic [LW-1:0] leaf, input logic [LVL_W-1:0] lvl);
        logic [L-1:0] n;
        n = L'(1);
        for (int k = 0; k < LW; k++) begin
            if (k < int'(lvl)) n = {n[L-2:0], leaf[k]};
        end
        return n;
    endfunction

    assign lfsr_leaf  = lfsr_reg[LW-1:0];
    assign last_read  = (lvl_reg == LVL_W'(L - 1)) && (slot_reg == SLOT_W'(Z - 1));
    assign last_evict = (lvl_reg == '0) && (slot_reg == SLOT_W'(Z - 1));

    always_comb begin
        cur_node = path_node(old_leaf_reg, lvl_reg);
        cur_idx  = SI_W'(cur_node) * SI_W'(Z) + SI_W'(slot_reg);
        for (int k = 0; k < LW; k++) lvl_mask[k] = (k < int'(lvl_reg));
    end

    // Priority searches: iterate downward so the lowest index wins
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        hit_found  = 1'b0;
        hit_idx    = '0;
        ev_found   = 1'b0;
        ev_idx     = '0;
        for (int i = STASH - 1; i >= 0; i--) begin
            if (!st_valid_reg[i]) begin
                free_found = 1'b1;
                free_idx   = ST_W'(i);
            end
            if (st_valid_reg[i] && st_addr[i] == rq_addr_reg) begin
                hit_found = 1'b1;
                hit_idx   = ST_W'(i);
            end
            if (st_valid_reg[i] && ((st_leaf[i] ^ old_leaf_reg) & lvl_mask) == '0) begin
                ev_found = 1'b1;
                ev_idx   = ST_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_hit    = 1'b0;
        rsp_rdata  = '0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = REMAP;
            end
            REMAP: state_next = READ;
            READ: if (last_read) state_next = RESPOND;
            RESPOND: begin
                rsp_valid  = 1'b1;
                rsp_hit    = hit_found;
                rsp_rdata  = hit_found ? st_data[hit_idx] : '0;
                state_next = EVICT;
            end
            EVICT: if (last_evict) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg      <= SEED;
            rq_write_reg  <= 1'b0;
            rq_addr_reg   <= '0;
            rq_wdata_reg  <= '0;
            old_leaf_reg  <= '0;
            new_leaf_reg  <= '0;
            lvl_reg       <= '0;
            slot_reg      <= '0;
            overflow_reg  <= 1'b0;
            bkt_valid_reg <= '0;
            pm_valid_reg  <= '0;
            st_valid_reg  <= '0;
        end else begin
            lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        rq_write_reg <= req_write;
                        rq_addr_reg  <= req_addr;
                        rq_wdata_reg <= req_wdata;
                        lvl_reg      <= '0;
                        slot_reg     <= '0;
                    end
                end
                REMAP: begin
                    // An unmapped block reads a random path so the access still looks ordinary
                    old_leaf_reg <= pm_valid_reg[rq_addr_reg] ? pm_leaf[rq_addr_reg] : lfsr_leaf;
                    new_leaf_reg <= lfsr_leaf;
                    if (rq_write_reg || pm_valid_reg[rq_addr_reg]) pm_valid_reg[rq_addr_reg] <= 1'b1;
                end
                READ: begin
                    if (bkt_valid_reg[cur_idx]) begin
                        bkt_valid_reg[cur_idx] <= 1'b0;
                        if (free_found) st_valid_reg[free_idx] <= 1'b1;
                        else            overflow_reg <= 1'b1;
                    end
                    if (slot_reg == SLOT_W'(Z - 1)) begin
                        slot_reg <= '0;
                        if (lvl_reg != LVL_W'(L - 1)) lvl_reg <= lvl_reg + LVL_W'(1);
                    end else begin
                        slot_reg <= slot_reg + SLOT_W'(1);
                    end
                end
                RESPOND: begin
                    if (!hit_found && rq_write_reg) begin
                        if (free_found) st_valid_reg[free_idx] <= 1'b1;
                        else            overflow_reg <= 1'b1;
                    end
                end
                EVICT: begin
                    bkt_valid_reg[cur_idx] <= ev_found;
                    if (ev_found) st_valid_reg[ev_idx] <= 1'b0;
                    if (slot_reg == SLOT_W'(Z - 1)) begin
                        slot_reg <= '0;
                        if (lvl_reg != '0) lvl_reg <= lvl_reg - LVL_W'(1);
                    end else begin
                        slot_reg <= slot_reg + SLOT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload storage: only meaningful where the matching valid bit is set, so no reset needed
    always_ff @(posedge clk) begin
        if (state_reg == REMAP && (rq_write_reg || pm_valid_reg[rq_addr_reg]))
            pm_leaf[rq_addr_reg] <= lfsr_leaf;
        if (state_reg == READ && bkt_valid_reg[cur_idx] && free_found) begin
            st_addr[free_idx] <= bkt_addr[cur_idx];
            st_leaf[free_idx] <= bkt_leaf[cur_idx];
            st_data[free_idx] <= bkt_data[cur_idx];
        end
        if (state_reg == RESPOND) begin
            if (hit_found) begin
                st_leaf[hit_idx] <= new_leaf_reg;
                if (rq_write_reg) st_data[hit_idx] <= rq_wdata_reg;
            end else if (rq_write_reg && free_found) begin
                st_addr[free_idx] <= rq_addr_reg;
                st_leaf[free_idx] <= new_leaf_reg;
                st_data[free_idx] <= rq_wdata_reg;
            end
        end
        if (state_reg == EVICT && ev_found) begin
            bkt_addr[cur_idx] <= st_addr[ev_idx];
            bkt_leaf[cur_idx] <= st_leaf[ev_idx];
            bkt_data[cur_idx] <= st_data[ev_idx];
        end
    end

    assign overflow = overflow_reg;

`ifdef ORAM_STASH_MON_EN
    localparam int OCC_W = $clog2(STASH + 1);
    logic [OCC_W-1:0] occ_now;
    logic [OCC_W-1:0] peak_reg;

    always_comb begin
        occ_now = '0;
        for (int i = 0; i < STASH; i++) occ_now = occ_now + OCC_W'(st_valid_reg[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  peak_reg <= '0;
        else if (occ_now > peak_reg) peak_reg <= occ_now;
    end

    assign stash_occ  = occ_now;
    assign stash_peak = peak_reg;
`endif
endmodule

// File: tb/tb_oram_path_ctrl.sv
// Bench for oram_path_ctrl: transaction-level Path-ORAM model checked every cycle, plus a
// small-tree instance (STASH=1) that must overflow. Honours ORAM_STASH_MON_EN when defined.
module tb_oram_path_ctrl;
    localparam int L = 6, Z = 3, STASH = 8, LW = L - 1, NN = 1 << L;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int RSP_K  = 1 + L * Z;
    localparam int DONE_K = 2 + 2 * L * Z;

    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_write = 1'b0;
    logic [L-1:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic req_ready, rsp_valid, rsp_hit, overflow;
    logic [63:0] rsp_rdata;

    logic rst2_n = 1'b0, r2_valid = 1'b0, r2_write = 1'b0;
    logic [1:0] r2_addr = '0;
    logic [7:0] r2_wdata = '0;
    logic r2_ready, r2_rsp_valid, r2_hit, r2_ovf;
    logic [7:0] r2_rdata;

`ifdef ORAM_STASH_MON_EN
    logic [3:0] stash_occ, stash_peak;
    logic [0:0] r2_occ, r2_peak;
`endif

    always #5 clk = ~clk;

    oram_path_ctrl #(.BLK_W(64), .L(L), .Z(Z), .STASH(STASH), .SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_hit(rsp_hit),
`ifdef ORAM_STASH_MON_EN
        .overflow(overflow), .stash_occ(stash_occ), .stash_peak(stash_peak)
`else
        .overflow(overflow)
`endif
    );

    oram_path_ctrl #(.BLK_W(8), .L(2), .Z(1), .STASH(1), .SEED(16'h1D2B)) dut2 (
        .clk(clk), .rst_n(rst2_n), .req_valid(r2_valid), .req_ready(r2_ready),
        .req_write(r2_write), .req_addr(r2_addr), .req_wdata(r2_wdata),
        .rsp_valid(r2_rsp_valid), .rsp_rdata(r2_rdata), .rsp_hit(r2_hit),
`ifdef ORAM_STASH_MON_EN
        .overflow(r2_ovf), .stash_occ(r2_occ), .stash_peak(r2_peak)
`else
        .overflow(r2_ovf)
`endif
    );

    int tests = 0, fails = 0;
    int cyc = 0, cyc_hs = 0;
    bit has_txn = 0;
    bit exp_hit = 0, exp_ovf = 0;
    logic [63:0] exp_rdata = '0;

    // Behavioural model state
    bit          m_bv [NN][Z];
    int          m_ba [NN][Z];
    int          m_bl [NN][Z];
    logic [63:0] m_bd [NN][Z];
    bit          m_pv [NN];
    int          m_pl [NN];
    bit          m_sv [STASH];
    int          m_sa [STASH];
    int          m_sl [STASH];
    logic [63:0] m_sd [STASH];
    bit          m_ovf;

    logic [15:0] lf_val = SEED;
    int          lf_n = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] lfsr_at(input int n);
        if (n < lf_n) begin lf_val = SEED; lf_n = 0; end
        while (lf_n < n) begin lf_val = lstep(lf_val); lf_n++; end
        return lf_val;
    endfunction

    function automatic int node_of(input int leaf, input int lv);
        int n;
        n = 1 << lv;
        for (int b = 0; b < lv; b++) n = n | (((leaf >> b) & 1) << (lv - 1 - b));
        return n;
    endfunction

    function automatic int first_free();
        for (int i = 0; i < STASH; i++) if (!m_sv[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NN; n++) begin
            m_pv[n] = 0;
            for (int s = 0; s < Z; s++) m_bv[n][s] = 0;
        end
        for (int i = 0; i < STASH; i++) m_sv[i] = 0;
        m_ovf = 0; exp_ovf = 0; has_txn = 0;
    endtask

    task automatic model_access(input bit wr, input int a, input logic [63:0] d, input logic [15:0] lf);
        int newl, oldl, node, fi, hi, msk;
        newl = int'(lf) & ((1 << LW) - 1);
        oldl = m_pv[a] ? m_pl[a] : newl;
        if (wr || m_pv[a]) begin m_pv[a] = 1; m_pl[a] = newl; end
        for (int lv = 0; lv < L; lv++) begin
            node = node_of(oldl, lv);
            for (int s = 0; s < Z; s++) if (m_bv[node][s]) begin
                m_bv[node][s] = 0;
                fi = first_free();
                if (fi < 0) m_ovf = 1;
                else begin
                    m_sv[fi] = 1; m_sa[fi] = m_ba[node][s]; m_sl[fi] = m_bl[node][s]; m_sd[fi] = m_bd[node][s];
                end
            end
        end
        hi = -1;
        for (int i = STASH - 1; i >= 0; i--) if (m_sv[i] && m_sa[i] == a) hi = i;
        if (hi >= 0) begin
            exp_hit = 1; exp_rdata = m_sd[hi]; m_sl[hi] = newl;
            if (wr) m_sd[hi] = d;
        end else begin
            exp_hit = 0; exp_rdata = '0;
            if (wr) begin
                fi = first_free();
                if (fi < 0) m_ovf = 1;
                else begin m_sv[fi] = 1; m_sa[fi] = a; m_sl[fi] = newl; m_sd[fi] = d; end
            end
        end
        for (int lv = L - 1; lv >= 0; lv--) begin
            node = node_of(oldl, lv);
            msk = (1 << lv) - 1;
            for (int s = 0; s < Z; s++) begin
                fi = -1;
                for (int i = STASH - 1; i >= 0; i--)
                    if (m_sv[i] && ((m_sl[i] & msk) == (oldl & msk))) fi = i;
                m_bv[node][s] = (fi >= 0);
                if (fi >= 0) begin
                    m_ba[node][s] = m_sa[fi]; m_bl[node][s] = m_sl[fi]; m_bd[node][s] = m_sd[fi];
                    m_sv[fi] = 0;
                end
            end
        end
        exp_ovf = m_ovf;
    endtask

    // Per-cycle comparison against the model's schedule and results
    always @(negedge clk) begin
        int k, cnt;
        if (rst_n) begin
            k = cyc - cyc_hs;
            if (has_txn && k < DONE_K) begin
                chk("busy_ready", req_ready, 0);
                if (k == RSP_K) begin
                    chk("rsp_valid", rsp_valid, 1);
                    chk("rsp_hit", rsp_hit, exp_hit);
                    chk("rsp_rdata", rsp_rdata, exp_rdata);
                end else begin
                    chk("rsp_quiet", rsp_valid, 0);
                end
            end else begin
                chk("idle_ready", req_ready, 1);
                chk("idle_rsp", rsp_valid, 0);
                chk("overflow", overflow, exp_ovf);
`ifdef ORAM_STASH_MON_EN
                cnt = 0;
                for (int i = 0; i < STASH; i++) cnt += int'(m_sv[i]);
                chk("stash_occ", 64'(stash_occ), 64'(cnt));
`endif
            end
        end
    end

    task automatic start_req(input bit wr, input int a, input logic [63:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) chk("ready_timeout", req_ready, 1);
        req_valid = 1; req_write = wr; req_addr = L'(a); req_wdata = d;
        @(posedge clk); #1;
        req_valid = 0;
        cyc_hs = cyc;
        model_access(wr, a, d, lfsr_at(cyc));
        has_txn = 1;
    endtask

    task automatic do_req(input bit wr, input int a, input logic [63:0] d,
                          output bit got_hit, output logic [63:0] got_data,
                          output int rsp_k, output int rdy_k);
        start_req(wr, a, d);
        got_hit = 0; got_data = '0; rsp_k = -1; rdy_k = -1;
        for (int i = 0; i < DONE_K + 5; i++) begin
            @(negedge clk);
            if (rsp_valid) begin got_hit = rsp_hit; got_data = rsp_rdata; rsp_k = cyc - cyc_hs; end
            if (req_ready) begin rdy_k = cyc - cyc_hs; break; end
            // Noise on the request port while busy must be ignored
            req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom); req_addr = L'($urandom);
            req_wdata = {$urandom, $urandom};
        end
        req_valid = 0;
        if (rdy_k < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic do_req2(input bit wr, input int a);
        int n;
        n = 0;
        @(negedge clk);
        while (!r2_ready && n < 50) begin @(negedge clk); n++; end
        r2_valid = 1; r2_write = wr; r2_addr = 2'(a); r2_wdata = 8'(a + 8'h40);
        @(posedge clk); #1;
        r2_valid = 0;
        n = 0;
        @(negedge clk);
        while (!r2_ready && n < 50) begin @(negedge clk); n++; end
        if (!r2_ready) chk("dut2_timeout", r2_ready, 1);
    endtask

    initial begin
        bit h;
        logic [63:0] dd;
        int rk, dk;
        bit wr;
        int a;
        model_reset();
        chk("lfsr_pin_1", lfsr_at(1), 64'hE270);
        repeat (3) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_hit", rsp_hit, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1; rst2_n = 1;
        repeat (8) @(negedge clk);

        // First write, read it back, read an unmapped block
        do_req(1, 5, 64'h1122334455667788, h, dd, rk, dk);
        chk("w5_hit", h, 0);
        chk("w5_rdata", dd, 0);
        chk("w5_rsp_latency", rk, 19);
        chk("w5_ready_latency", dk, 38);
`ifdef ORAM_STASH_MON_EN
        chk("stash_peak_ge1", stash_peak >= 1, 1);
`endif
        do_req(0, 5, 64'h0, h, dd, rk, dk);
        chk("r5_hit", h, 1);
        chk("r5_rdata", dd, 64'h1122334455667788);
        do_req(0, 9, 64'h0, h, dd, rk, dk);
        chk("r9_hit", h, 0);
        chk("r9_rdata", dd, 0);
        do_req(0, 9, 64'h0, h, dd, rk, dk);
        chk("r9_again_hit", h, 0);

        // Fill every address, read back in reverse
        for (int i = 0; i < NN; i++) do_req(1, i, 64'(i), h, dd, rk, dk);
        for (int i = NN - 1; i >= 0; i--) begin
            do_req(0, i, 64'h0, h, dd, rk, dk);
            if (!m_ovf) begin
                chk("fill_hit", h, 1);
                chk("fill_data", dd, 64'(i));
            end
        end

        // Randomised traffic
        for (int i = 0; i < 60; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, NN - 1);
            do_req(wr, a, {$urandom, $urandom}, h, dd, rk, dk);
        end

        // Reset during READ of a write to address 3
        start_req(1, 3, 64'hDEADBEEF00000003);
        repeat (5) @(negedge clk);
        rst_n = 0;
        model_reset();
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_ready", req_ready, 1);
        chk("midrst_overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (45) @(negedge clk);
        do_req(0, 3, 64'h0, h, dd, rk, dk);
        chk("after_rst_r3_hit", h, 0);
        chk("after_rst_r3_rdata", dd, 0);

        // Tiny tree with a one-entry stash: three distinct writes must overflow
        do_req2(1, 0);
        chk("dut2_ovf_first", r2_ovf, 0);
        do_req2(1, 1);
        do_req2(1, 2);
        chk("dut2_ovf_set", r2_ovf, 1);
        do_req2(0, 3);
        chk("dut2_ovf_sticky", r2_ovf, 1);
        @(negedge clk);
        rst2_n = 0;
        #1;
        chk("dut2_ovf_reset", r2_ovf, 0);
        @(negedge clk);
        rst2_n = 1;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
